// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, sticky C/Z/N/V flags and a one-bit-per-clock shifter.
// Latency: 1 cycle for single-cycle ops; SHL by k>0 takes k+1 cycles. No overlap, so at most one op every 2 cycles.
// Backpressure: the result and flags are held in DONE until out_ready; in_ready is high only in IDLE.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   operand handshake; a, b and opcode are captured when the operation is accepted
//   out_valid/ready  result handshake; out and cout are the registered result and its carry/shift-out
//   c/z/n/v_flag     flags of the last completed operation (held until the next one completes)
//
// Optional build macro ALU_SEQ_SAT_EN: ADD/ADC/SUB saturate (unsigned); cout and v still describe
// the raw, unsaturated arithmetic.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             c_flag,
  output logic             z_flag,
  output logic             n_flag,
  output logic             v_flag
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             c_q, z_q, n_q, v_q;
  logic [WIDTH-1:0] shreg_q;   // working copy of operand A while shifting
  logic [SHW-1:0]   cnt_q;     // shifts still to perform

  // Single-cycle datapath, evaluated on the live inputs in the accepting cycle.
  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic             is_sub;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_d;
  logic             cout_d;
  logic             v_d;
  logic [WIDTH-1:0] shl_d;

  always_comb begin
    is_sub = (opcode == OP_SUB);
    // SUB is a + ~b + 1 through the same adder; ADC feeds in the carry held before this op.
    b_op   = is_sub ? ~b : b;
    cin    = is_sub ? 1'b1 : ((opcode == OP_ADC) ? c_q : 1'b0);
    sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};

    res_d  = '0;
    cout_d = 1'b0;
    v_d    = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADC: begin
        res_d  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        // Signed overflow: both adder inputs share a sign that the sum does not.
        v_d    = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SEQ_SAT_EN
        if (is_sub) begin
          if (!sum[WIDTH]) res_d = '0;   // borrow -> clamp to zero
        end else if (sum[WIDTH]) begin
          res_d = '1;                    // carry out -> clamp to all ones
        end
`endif
      end
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_SHL: res_d = a;                 // only reached here with a zero shift amount
      OP_CMP: res_d = {{(WIDTH-1){1'b0}}, (a > b)};
      default: res_d = '0;
    endcase
  end

  assign shl_d = {shreg_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cout_q      <= 1'b0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if ((opcode == OP_SHL) && (b[SHW-1:0] != '0)) begin
              shreg_q <= a;
              cnt_q   <= b[SHW-1:0];
              state_q <= S_SHIFT;
            end else begin
              out_q       <= res_d;
              cout_q      <= cout_d;
              c_q         <= cout_d;
              z_q         <= (res_d == '0);
              n_q         <= res_d[WIDTH-1];
              v_q         <= v_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end

        S_SHIFT: begin
          shreg_q <= shl_d;
          cnt_q   <= cnt_q - CNT_ONE;
          // Result and flags only change on the final step, so out/cout keep the
          // previous result until the new one is complete.
          if (cnt_q == CNT_ONE) begin
            out_q       <= shl_d;
            cout_q      <= shreg_q[WIDTH-1];
            c_q         <= shreg_q[WIDTH-1];
            z_q         <= (shl_d == '0);
            n_q         <= shl_d[WIDTH-1];
            v_q         <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign cout      = cout_q;
  assign c_flag    = c_q;
  assign z_flag    = z_q;
  assign n_flag    = n_q;
  assign v_flag    = v_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

`ifdef ALU_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, ADC = 3'd5, SHL = 3'd6, CMP = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [2:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       cout, c_flag, z_flag, n_flag, v_flag;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout),
    .c_flag(c_flag), .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {c_flag, z_flag, n_flag, v_flag};
  endfunction

  // Reference model from the opcode definitions, using plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input int ua, input int ub, input bit cin,
                                output int r, output bit co, output bit ov, output int lat);
    int sa, sb, s, ss, k;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r = 0; co = 1'b0; ov = 1'b0; lat = 1;
    case (op)
      ADD, ADC: begin
        s  = ua + ub + ((op == ADC) ? int'(cin) : 0);
        ss = sa + sb + ((op == ADC) ? int'(cin) : 0);
        co = (s > 255);
        ov = (ss > 127) || (ss < -128);
        r  = s % 256;
        if (SAT && co) r = 255;
      end
      SUB: begin
        s  = ua - ub;
        ss = sa - sb;
        co = (ua >= ub);
        ov = (ss > 127) || (ss < -128);
        r  = (s + 256) % 256;
        if (SAT && !co) r = 0;
      end
      AND_: r = ua & ub;
      OR_:  r = ua | ub;
      XOR_: r = ua ^ ub;
      SHL: begin
        k   = ub % 8;
        r   = (ua << k) % 256;
        co  = (k > 0) ? (((ua >> (8 - k)) & 1) == 1) : 1'b0;
        lat = (k > 0) ? k + 1 : 1;
      end
      default: r = (ua > ub) ? 1 : 0;
    endcase
  endfunction

  // Presents one operation, returns latency (-1 on timeout) and whether in_ready rose while busy.
  // Called and returns at 1 time unit after a rising edge.
  task automatic do_op(input logic [2:0] op, input logic [7:0] oa, input logic [7:0] ob,
                       output int lat, output bit rdy_bad);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = op; a = oa; b = ob;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the captured operands must be used.
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
    lat = 1; rdy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_cout;
    logic [3:0] exp_f;     // {C, Z, N, V}
    int         exp_lat;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int  lat;
    bit  rdy_bad;
    int  r, elat;
    bit  co, ov;
    bit  mc;
    logic [2:0] op;
    logic [7:0] ra, rb, hold_out;

    tbl[0]  = '{ADD,  8'hF0, 8'h20, SAT ? 8'hFF : 8'h10, 1'b1, SAT ? 4'b1010 : 4'b1000, 1};
    tbl[1]  = '{SUB,  8'h05, 8'h05, 8'h00, 1'b1, 4'b1100, 1};
    tbl[2]  = '{SUB,  8'h03, 8'h05, SAT ? 8'h00 : 8'hFE, 1'b0, SAT ? 4'b0100 : 4'b0010, 1};
    tbl[3]  = '{ADD,  8'hFF, 8'h01, SAT ? 8'hFF : 8'h00, 1'b1, SAT ? 4'b1010 : 4'b1100, 1};
    tbl[4]  = '{ADC,  8'h00, 8'h00, 8'h01, 1'b0, 4'b0000, 1};
    tbl[5]  = '{ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 4'b0011, 1};
    tbl[6]  = '{SHL,  8'h81, 8'h03, 8'h08, 1'b0, 4'b0000, 4};
    tbl[7]  = '{SHL,  8'h81, 8'h01, 8'h02, 1'b1, 4'b1000, 2};
    tbl[8]  = '{AND_, 8'hF0, 8'h3C, 8'h30, 1'b0, 4'b0000, 1};
    tbl[9]  = '{OR_,  8'h80, 8'h01, 8'h81, 1'b0, 4'b0010, 1};
    tbl[10] = '{XOR_, 8'hAA, 8'hAA, 8'h00, 1'b0, 4'b0100, 1};
    tbl[11] = '{CMP,  8'h05, 8'h03, 8'h01, 1'b0, 4'b0000, 1};
    tbl[12] = '{CMP,  8'h03, 8'h05, 8'h00, 1'b0, 4'b0100, 1};
    tbl[13] = '{SHL,  8'h5A, 8'h08, 8'h5A, 1'b0, 4'b0000, 1};
    tbl[14] = '{SUB,  8'h80, 8'h01, 8'h7F, 1'b1, 4'b1001, 1};
    tbl[15] = '{ADC,  8'h10, 8'h20, 8'h31, 1'b0, 4'b0000, 1};
    tbl[16] = '{SHL,  8'h01, 8'h07, 8'h80, 1'b0, 4'b0010, 8};
    tbl[17] = '{SHL,  8'hFF, 8'h07, 8'h80, 1'b1, 4'b1010, 8};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out",       32'(out),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_flags",     32'(flags()),   32'd0);

    // Directed table, applied in order (ADC rows rely on the preceding carry)
    for (int i = 0; i < 18; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, rdy_bad);
      chk($sformatf("row%0d_lat", i),   32'(lat),      32'(tbl[i].exp_lat));
      chk($sformatf("row%0d_out", i),   32'(out),      32'(tbl[i].exp_out));
      chk($sformatf("row%0d_cout", i),  32'(cout),     32'(tbl[i].exp_cout));
      chk($sformatf("row%0d_flags", i), 32'(flags()),  32'(tbl[i].exp_f));
      chk($sformatf("row%0d_busy", i),  32'(rdy_bad),  32'd0);
      release_out();
    end

    // Backpressure: result held for 5 cycles, in_valid pulses ignored
    do_op(ADD, 8'h7F, 8'h01, lat, rdy_bad);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; opcode = ADD; a = 8'h01; b = 8'h01;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_out", i),   32'(out),       32'h80);
      chk($sformatf("hold%0d_flags", i), 32'(flags()),   32'b0011);
      chk($sformatf("hold%0d_vld", i),   32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_rdy", i),   32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    release_out();
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready",  32'(in_ready),  32'd1);
    chk("release_flags",     32'(flags()),   32'b0011);

    // Reset during a long shift abandons it
    in_valid = 1'b1; opcode = SHL; a = 8'hFF; b = 8'h07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out",       32'(out),       32'd0);
    chk("midrst_cout",      32'(cout),      32'd0);
    chk("midrst_flags",     32'(flags()),   32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    co = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) co = 1'b1;
    end
    chk("midrst_no_result", 32'(co), 32'd0);

    // Randomised ops against the model, with random result backpressure
    mc = 1'b0;
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      model(op, int'(ra), int'(rb), mc, r, co, ov, elat);
      do_op(op, ra, rb, lat, rdy_bad);
      chk($sformatf("rnd%0d_op%0d_lat", i, op),   32'(lat),     32'(elat));
      chk($sformatf("rnd%0d_op%0d_out", i, op),   32'(out),     32'(r));
      chk($sformatf("rnd%0d_op%0d_cout", i, op),  32'(cout),    32'(co));
      chk($sformatf("rnd%0d_op%0d_flags", i, op), 32'(flags()),
          32'({co, (r == 0), (r >= 128), ov}));
      mc = co;
      hold_out = out;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      chk($sformatf("rnd%0d_stable", i), 32'(out), 32'(hold_out));
      release_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
